// File: rtl/keypad_scanner_sj.sv
// rtl/keypad_scanner_sj.sv - 4x4 matrix keypad scanner with press/release debounce and two-digit key history
module keypad_scanner_sj #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       key_valid
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN             = 2'd0,
    DEBOUNCE_PRESS   = 2'd1,
    HELD             = 2'd2,
    DEBOUNCE_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [1:0]          col_q, col_nxt;
  logic [1:0]          row_q, row_nxt;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_nxt;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_nxt;
  logic [3:0]          s1_q, s1_nxt;
  logic [3:0]          s2_q, s2_nxt;
  logic                kv_q, kv_nxt;
  logic [3:0]          rows_meta;
  logic [3:0]          rows_sync;

  logic                any_low;
  logic                all_high;
  logic                latched_low;
  logic [1:0]          low_row;

  // Map a (row, column) position onto the printed legend of the keypad.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines; idles high like the pull-ups.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  assign any_low     = ~(&rows_sync);
  assign all_high    = &rows_sync;
  assign latched_low = ~rows_sync[row_q];

  // Lowest-index active row wins when several rows are pulled low together.
  always_comb begin
    low_row = 2'd3;
    if (!rows_sync[0])      low_row = 2'd0;
    else if (!rows_sync[1]) low_row = 2'd1;
    else if (!rows_sync[2]) low_row = 2'd2;
  end

  // Registered state: FSM, column pointer, latched row, counters and key history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      s1_q       <= 4'h0;
      s2_q       <= 4'h0;
      kv_q       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      col_q      <= col_nxt;
      row_q      <= row_nxt;
      scan_cnt_q <= scan_cnt_nxt;
      deb_cnt_q  <= deb_cnt_nxt;
      s1_q       <= s1_nxt;
      s2_q       <= s2_nxt;
      kv_q       <= kv_nxt;
    end
  end

  // Next-state logic: scan columns, debounce the press, hold, debounce the release.
  always_comb begin
    state_nxt    = state_q;
    col_nxt      = col_q;
    row_nxt      = row_q;
    scan_cnt_nxt = scan_cnt_q;
    deb_cnt_nxt  = deb_cnt_q;
    s1_nxt       = s1_q;
    s2_nxt       = s2_q;
    kv_nxt       = 1'b0;

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_nxt = '0;
          if (any_low) begin
            // Column stays frozen; only the row is captured.
            state_nxt   = DEBOUNCE_PRESS;
            row_nxt     = low_row;
            deb_cnt_nxt = '0;
          end else begin
            col_nxt = col_q + 2'd1;
          end
        end else begin
          scan_cnt_nxt = scan_cnt_q + SCAN_W'(1);
        end
      end

      DEBOUNCE_PRESS: begin
        if (latched_low) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_nxt   = HELD;
            deb_cnt_nxt = '0;
            s2_nxt      = s1_q;
            s1_nxt      = key_code(row_q, col_q);
            kv_nxt      = 1'b1;
          end else begin
            deb_cnt_nxt = deb_cnt_q + DEB_W'(1);
          end
        end else begin
          // Bounce: give up on this key and move on to the next column.
          state_nxt    = SCAN;
          col_nxt      = col_q + 2'd1;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end
      end

      HELD: begin
        if (all_high) begin
          state_nxt   = DEBOUNCE_RELEASE;
          deb_cnt_nxt = '0;
        end
      end

      DEBOUNCE_RELEASE: begin
        if (!all_high) begin
          state_nxt   = HELD;
          deb_cnt_nxt = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_nxt    = SCAN;
          col_nxt      = col_q + 2'd1;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end else begin
          deb_cnt_nxt = deb_cnt_q + DEB_W'(1);
        end
      end

      default: begin
        state_nxt = SCAN;
      end
    endcase
  end

  assign cols      = ~(4'b0001 << col_q);
  assign s1        = s1_q;
  assign s2        = s2_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scanner_sj.sv
// tb/tb_keypad_scanner_sj.sv - scoreboard bench for keypad_scanner_sj with a behavioural keypad matrix
module tb_keypad_scanner_sj;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  s1;
  logic [3:0]  s2;
  logic        key_valid;

  logic [15:0] pressed = 16'h0000;
  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_count = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  sb_e;
  logic [3:0]  exp_s1 = 4'h0;
  logic [3:0]  exp_s2 = 4'h0;
  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0]  col_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner_sj #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .s1        (s1),
    .s2        (s2),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  // Scoreboard consumer: every key_valid pulse must match the oldest expected history.
  always @(negedge clk) begin
    if (reset && key_valid) begin
      pulse_count++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: key_valid=1 s1=%h s2=%h with no press pending", s1, s2);
      end else begin
        sb_e = sb_q.pop_front();
        if ({s1, s2} !== sb_e) begin
          miscompares++;
          $display("FAIL pulse_history: s1/s2=%h/%h expected %h/%h", s1, s2, sb_e[7:4], sb_e[3:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic expect_key(input int r, input int c);
    exp_s2 = exp_s1;
    exp_s1 = kmap[r*4+c];
    sb_q.push_back({exp_s1, exp_s2});
  endtask

  task automatic press_release(input logic [15:0] mask, input int hold, output int pulses);
    int pc;
    pc = pulse_count;
    @(negedge clk);
    pressed = mask;
    repeat (hold) @(negedge clk);
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    #1;
    pulses = pulse_count - pc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    vectors++; if (cols !== 4'b1110) begin miscompares++; $display("FAIL reset_cols: got %b expected 1110", cols); end
    vectors++; if (s1 !== 4'h0) begin miscompares++; $display("FAIL reset_s1: got %h expected 0", s1); end
    vectors++; if (s2 !== 4'h0) begin miscompares++; $display("FAIL reset_s2: got %h expected 0", s2); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_kv: got %b expected 0", key_valid); end
  endtask

  task automatic test_idle_scan();
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (cols !== col_tab[(k/4)%4]) begin
        miscompares++;
        $display("FAIL idle_scan_cols: cycle %0d got %b expected %b", k, cols, col_tab[(k/4)%4]);
      end
    end
    #1;
    vectors++; if (pulse_count !== 0) begin miscompares++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", pulse_count); end
    vectors++; if ({s1, s2} !== 8'h00) begin miscompares++; $display("FAIL idle_history: got %h/%h expected 0/0", s1, s2); end
  endtask

  task automatic test_key6();
    int pc;
    logic [3:0] exp_cols;
    expect_key(1, 2);
    pc = pulse_count;
    pressed = 16'h0040;
    repeat (30) @(negedge clk);
    pressed = 16'h0000;
    // Frozen on column 2 until 3 cycles of sync/detection plus DEBOUNCE_CNT release cycles.
    for (int k = 1; k <= 3 + DEBOUNCE_CNT; k++) begin
      @(negedge clk);
      exp_cols = (k < 3 + DEBOUNCE_CNT) ? col_tab[2] : col_tab[3];
      vectors++;
      if (cols !== exp_cols) begin
        miscompares++;
        $display("FAIL key6_release_cols: %0d cycles after release got %b expected %b", k, cols, exp_cols);
      end
    end
    repeat (5) @(negedge clk);
    #1;
    vectors++; if (pulse_count - pc !== 1) begin miscompares++; $display("FAIL key6_pulses: got %0d expected 1", pulse_count - pc); end
    vectors++; if ({s1, s2} !== 8'h60) begin miscompares++; $display("FAIL key6_history: got %h/%h expected 6/0", s1, s2); end
  endtask

  task automatic test_key0();
    int p;
    expect_key(3, 1);
    press_release(16'h2000, 40, p);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL key0_pulses: got %0d expected 1", p); end
    vectors++; if ({s1, s2} !== 8'h06) begin miscompares++; $display("FAIL key0_history: got %h/%h expected 0/6", s1, s2); end
  endtask

  task automatic test_bounce();
    int pc;
    logic [3:0] prev;
    logic found;
    found = 1'b0;
    prev = cols;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cols == col_tab[3] && prev != col_tab[3]) found = 1'b1;
      prev = cols;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL bounce_sync: got no column-3 entry expected one within 40 cycles"); end
    repeat (3) @(negedge clk);
    expect_key(0, 3);
    pc = pulse_count;
    pressed = 16'h0008;
    repeat (3) @(negedge clk);
    pressed = 16'h0000;
    @(negedge clk);
    pressed = 16'h0008;
    #1;
    vectors++; if (pulse_count !== pc) begin miscompares++; $display("FAIL bounce_first_low: got %0d pulses expected 0", pulse_count - pc); end
    repeat (20) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      pressed = 16'h0000;
      repeat (2) @(negedge clk);
      pressed = 16'h0008;
      repeat (2) @(negedge clk);
    end
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    #1;
    vectors++; if (pulse_count - pc !== 1) begin miscompares++; $display("FAIL bounce_pulses: got %0d expected 1", pulse_count - pc); end
    vectors++; if ({s1, s2} !== 8'hA0) begin miscompares++; $display("FAIL bounce_history: got %h/%h expected A/0", s1, s2); end
  endtask

  task automatic test_hold_two();
    int pc;
    int p;
    expect_key(1, 1);
    pc = pulse_count;
    @(negedge clk);
    pressed = 16'h0020;
    for (int i = 0; i < 60 && pulse_count == pc; i++) begin
      @(negedge clk);
      #1;
    end
    vectors++; if (pulse_count - pc !== 1) begin miscompares++; $display("FAIL hold5_accept: got %0d pulses expected 1 within 60 cycles", pulse_count - pc); end
    @(negedge clk);
    pressed = 16'h0420;
    repeat (30) @(negedge clk);
    pressed = 16'h0020;
    repeat (10) @(negedge clk);
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    #1;
    vectors++; if (pulse_count - pc !== 1) begin miscompares++; $display("FAIL hold_ignore9: got %0d pulses expected 1", pulse_count - pc); end
    vectors++; if ({s1, s2} !== 8'h5A) begin miscompares++; $display("FAIL hold5_history: got %h/%h expected 5/A", s1, s2); end
    expect_key(2, 2);
    press_release(16'h0400, 40, p);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL key9_pulses: got %0d expected 1", p); end
    vectors++; if ({s1, s2} !== 8'h95) begin miscompares++; $display("FAIL key9_history: got %h/%h expected 9/5", s1, s2); end
  endtask

  task automatic test_back_to_back();
    int p;
    expect_key(2, 2);
    press_release(16'h0400, 40, p);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL repeat9_pulses: got %0d expected 1", p); end
    vectors++; if ({s1, s2} !== 8'h99) begin miscompares++; $display("FAIL repeat9_history: got %h/%h expected 9/9", s1, s2); end
  endtask

  task automatic test_multi_row();
    int p;
    expect_key(1, 0);
    press_release(16'h0110, 40, p);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL multirow_pulses: got %0d expected 1", p); end
    vectors++; if ({s1, s2} !== 8'h49) begin miscompares++; $display("FAIL multirow_history: got %h/%h expected 4/9", s1, s2); end
  endtask

  task automatic test_reset_abort();
    int pc;
    @(negedge clk);
    reset = 1'b0;
    pressed = 16'h0000;
    exp_s1 = 4'h0;
    exp_s2 = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pressed = 16'h0001;
    pc = pulse_count;
    // Detection after 4 edges, then 5 debounce increments.
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (cols !== 4'b1110) begin miscompares++; $display("FAIL abort_cols: got %b expected 1110", cols); end
    vectors++; if ({s1, s2} !== 8'h00) begin miscompares++; $display("FAIL abort_history: got %h/%h expected 0/0", s1, s2); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL abort_kv: got %b expected 0", key_valid); end
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    vectors++; if (cols !== 4'b1101) begin miscompares++; $display("FAIL abort_restart_cols: got %b expected 1101", cols); end
    repeat (20) @(negedge clk);
    #1;
    vectors++; if (pulse_count !== pc) begin miscompares++; $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulse_count - pc); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_key6();
    test_key0();
    test_bounce();
    test_hold_two();
    test_back_to_back();
    test_multi_row();
    test_reset_abort();
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending presses expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_sj.md
KEYPAD_SCANNER_SJ -- requirements
Module: keypad_scanner_sj

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles each column is driven before advancing.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 50000, meaning consecutive stable synchronized cycles required to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state is clocked on posedge clk.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port rows, input, 4, keypad row lines, active-low, externally pulled up.
REQ-006 The block SHALL have port cols, output, 4, keypad column drive, active-low one-hot.
REQ-007 The block SHALL have port s1, output, 4, most recently accepted key code; feeds the display multiplexer's right-digit input.
REQ-008 The block SHALL have port s2, output, 4, previously accepted key code; feeds the display multiplexer's left-digit input.
REQ-009 The block SHALL have port key_valid, output, 1, one-cycle pulse on each accepted press.

Function
REQ-010 rows SHALL pass through a 2-flop synchronizer; all decisions SHALL use only the synchronized value.
REQ-011 Key code map (row r, col c, index 0..3): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE.
REQ-013 SCAN: exactly one cols bit low; column advances 0->1->2->3->0 every SCAN_DIV cycles; dwell counter resets on each advance.
REQ-014 SCAN: on the final dwell cycle of a column, if any synchronized row is low, the FSM SHALL latch column and row and enter DEBOUNCE_PRESS; cols SHALL freeze on that column.
REQ-015 If several rows are low at once, the lowest-index row SHALL be latched.
REQ-016 DEBOUNCE_PRESS: the counter SHALL increment each cycle the latched row is low; if the latched row goes high, the FSM SHALL return to SCAN at the next column with the counter cleared.
REQ-017 When the counter reaches DEBOUNCE_CNT-1 with the latched row still low, on the next edge: s2<=s1, s1<=key code, key_valid=1 for that one cycle, state<=HELD.
REQ-018 HELD: cols frozen; when all synchronized rows are high, the FSM SHALL enter DEBOUNCE_RELEASE with the counter cleared.
REQ-019 DEBOUNCE_RELEASE: after DEBOUNCE_CNT consecutive all-high cycles the FSM SHALL enter SCAN at the next column; any low row SHALL send it back to HELD.
REQ-020 Presses of other keys while in HELD or DEBOUNCE_RELEASE SHALL be ignored; no second key SHALL be registered until the first is released.
REQ-021 Identical consecutive keys SHALL each shift, giving s1 == s2.
REQ-022 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap within a state.
REQ-023 s1, s2 and key_valid SHALL change only on the REQ-017 edge or on reset.

Reset
REQ-024 reset low SHALL immediately force state=SCAN, cols=4'b1110, s1=4'h0, s2=4'h0, key_valid=0, all counters and synchronizer flops to their idle values (synchronizer to 4'b1111).
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no shift; after release, scanning SHALL restart at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-026 Reset, rows=4'hF for 40 cycles -> cols cycles 1110,1101,1011,0111 at 4 cycles each; s1=s2=0; key_valid never high.
REQ-027 Press r1c2 (key 6) held 30 cycles, then release -> exactly one key_valid pulse; s1=4'h6, s2=4'h0; scanning resumes after 8 high cycles.
REQ-028 Then press r3c1 (key 0) -> s1=4'h0, s2=4'h6; one pulse.
REQ-029 Bounce: row low 3 cycles, high 1, low 20 -> no accept on the first low; a single accept after 8 stable cycles; release bouncing high/low 3 times -> no extra pulse.
REQ-030 Hold key 5, press key 9 simultaneously -> only 5 registered; after both are released and 9 is pressed alone, 9 is registered (s1=9, s2=5).
REQ-031 Assert reset at counter=5 in DEBOUNCE_PRESS -> s1/s2 unchanged at 0, cols=1110, no pulse.
